bomb_slot_manager: RTL and testbench
====================================

Name: bomb_slot_manager

Overview:
- Producer of the bomb/explosion state consumed by the explosion-rendering block: owns the 6 bomb slots, their cell coordinates, fuse timers and explosion windows.
- Drives bomb_x/bomb_y/crack_num in the packed 6-slot format.
- Sits between the player controller, which issues place requests, and the VGA overlay logic, which reads slot state.
- Cell coordinates are block units: pixel / 16.

Parameters:
FUSE_TICKS, 180, ticks from placement to detonation (1..255)
CRACK_TICKS, 30, ticks an explosion stays visible (1..255)
CNT_W, 8, width of per-slot tick counter

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
tick  input  1  game-time enable, one-cycle pulse; all timers advance only on tick
place  input  1  one-cycle place request from player controller
place_x  input  6  cell column of requested bomb
place_y  input  6  cell row of requested bomb
place_ok  output  1  one-cycle pulse: request accepted
place_rej  output  1  one-cycle pulse: request rejected (full or cell occupied)
bomb_x  output  [1:36]  slot k column in bits [6k-5:6k], k=1..6
bomb_y  output  [1:36]  slot k row, same packing
bomb_live  output  [1:6]  bit k: slot k fuse burning
crack_num  output  [1:6]  bit k: slot k exploding
bomb_count  output  3  number of non-idle slots (0..6)

Behaviour:
- Clocking: single clock clk. Reset is synchronous and active-high. All state is registered.
- Reset values: all slots IDLE; bomb_x, bomb_y, bomb_live, crack_num and bomb_count = 0; place_ok and place_rej = 0.
- Reset mid-operation aborts all fuses and explosions in the same edge.
- Each slot runs a 3-state FSM:
  - IDLE -> FUSE on allocation. Coordinates are latched, counter = FUSE_TICKS, bomb_live[k] = 1.
  - FUSE: on tick, if counter == 1 -> CRACK. Counter = CRACK_TICKS, bomb_live[k] = 0, crack_num[k] = 1. Otherwise counter decrements.
  - CRACK: on tick, if counter == 1 -> IDLE. crack_num[k] = 0, coordinates cleared to 0. Otherwise counter decrements.
- Placement, evaluated on the edge where place = 1:
  - Reject if all 6 slots are non-idle.
  - Reject if any non-idle slot holds the same (place_x, place_y).
  - Otherwise accept into the lowest-numbered IDLE slot.
  - place_ok or place_rej pulses in the cycle after the request edge, and the slot outputs update at the same edge.
  - Latency from place to visible outputs: 1 cycle.
- Simultaneous events:
  - A slot leaving CRACK->IDLE on the same edge as a place request is not free for that request.
  - A request arriving together with tick: allocation and the new slot's first decrement do not coincide. The first decrement happens on the next tick.
  - Multiple slots may transition on the same tick, independently.
- bomb_count is registered and equals the popcount of (bomb_live | crack_num) after each edge.
- place held high for N cycles is treated as N independent requests. The second request is rejected as occupying the same cell.
- Invariant: bomb_live & crack_num == 0 at all times.

Optional Feature:
- Macro: CHAIN_REACT_EN.
- Defined: on any tick, a FUSE slot enters CRACK immediately if some slot j already in CRACK satisfies either condition:
  - bomb_x[j] == its x and x is odd, or
  - bomb_y[j] == its y and y is odd.
  This matches the row/column blast shape drawn by the renderer. Chain detonation evaluates against CRACK state at the start of the tick, so cascades propagate one hop per tick.
- Undefined: fuses expire only by their own counter.

Decomposition:
- Shared package bomb_pkg:
  - slot state encoding (IDLE/FUSE/CRACK)
  - NUM_SLOTS = 6
  - COORD_W = 6
  - BLOCK_W = 16
- One sub-module, bomb_slot: per-slot FSM, counter and coordinate registers. It has inputs alloc, tick, chain_hit and outputs live, crack, x, y.
- The top level instantiates bomb_slot 6 times and contains:
  - priority allocator
  - duplicate-cell comparator
  - output packing
  - popcount

Test Plan:
- Reset, then place (3,5) with FUSE_TICKS=4 and CRACK_TICKS=2 -> next cycle place_ok=1, bomb_x[1:6]=3, bomb_y[1:6]=5, bomb_live=6'b100000. After 4 ticks crack_num=6'b100000. After 2 more ticks all zero and bomb_count=0.
- Place 6 distinct cells, then a 7th at (9,9) -> six place_ok pulses, bomb_count=6, 7th gives place_rej=1 with outputs unchanged.
- Place (7,7) twice on consecutive cycles -> place_ok then place_rej; only slot 1 is used.
- Free slot 2 (explodes and expires) while slots 1 and 3 are live, then place (1,1) -> allocated to slot 2 (bits [7:12]=1).
- Assert rst while 3 slots are in FUSE/CRACK -> next cycle all outputs 0. A place on the first post-reset cycle is accepted into slot 1.
- With CHAIN_REACT_EN: bomb A (3,4) with fuse 2, bomb B (3,8) placed later with fuse 10 -> B enters CRACK on the tick after A does (shared odd column 3). Without the macro, B waits its full fuse.

Source files
------------

// File: rtl/bomb_pkg.sv
// bomb_pkg: shared slot state encoding, geometry constants and helpers
package bomb_pkg;
  typedef enum logic [1:0] {S_IDLE, S_FUSE, S_CRACK} slot_state_t;
  localparam int NUM_SLOTS = 6;
  localparam int COORD_W = 6;
  localparam int BLOCK_W = 16;
  function automatic logic [2:0] popcount6(input logic [NUM_SLOTS-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < NUM_SLOTS; i++) n = n + 3'(v[i]);
    return n;
  endfunction
endpackage

// File: rtl/bomb_slot.sv
// bomb_slot: one bomb slot -- IDLE/FUSE/CRACK FSM, tick counter and latched cell
module bomb_slot
  import bomb_pkg::*;
#(
  parameter int FUSE_TICKS = 180,
  parameter int CRACK_TICKS = 30,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               alloc,
  input  logic               chain_hit,
  input  logic [COORD_W-1:0] place_x,
  input  logic [COORD_W-1:0] place_y,
  output logic               live,
  output logic               crack,
  output logic               busy_next,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y
);
  slot_state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [COORD_W-1:0] x_n, y_n;
  // state, counter and coordinate registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      x <= '0;
      y <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      x <= x_n;
      y <= y_n;
    end
  end
  // next state: allocation arms the fuse, ticks count down fuse then explosion
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    x_n = x;
    y_n = y;
    case (state)
      S_IDLE:
        if (alloc) begin
          state_n = S_FUSE;
          cnt_n = CNT_W'(FUSE_TICKS);
          x_n = place_x;
          y_n = place_y;
        end
      S_FUSE:
        if (tick) begin
          state_n = (cnt == CNT_W'(1) || chain_hit) ? S_CRACK : S_FUSE;
          cnt_n = (cnt == CNT_W'(1) || chain_hit) ? CNT_W'(CRACK_TICKS) : cnt - CNT_W'(1);
        end
      S_CRACK:
        if (tick) begin
          state_n = (cnt == CNT_W'(1)) ? S_IDLE : S_CRACK;
          cnt_n = cnt - CNT_W'(1);
          x_n = (cnt == CNT_W'(1)) ? '0 : x;
          y_n = (cnt == CNT_W'(1)) ? '0 : y;
        end
      default: state_n = S_IDLE;
    endcase
  end
  assign live = state == S_FUSE;
  assign crack = state == S_CRACK;
  assign busy_next = state_n != S_IDLE;
endmodule

// File: rtl/bomb_slot_manager.sv
// bomb_slot_manager: six bomb slots with allocator and duplicate check; optional CHAIN_REACT_EN chain detonation
module bomb_slot_manager
  import bomb_pkg::*;
#(
  parameter int FUSE_TICKS = 180,
  parameter int CRACK_TICKS = 30,
  parameter int CNT_W = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           tick,
  input  logic                           place,
  input  logic [COORD_W-1:0]             place_x,
  input  logic [COORD_W-1:0]             place_y,
  output logic                           place_ok,
  output logic                           place_rej,
  output logic [1:NUM_SLOTS*COORD_W]     bomb_x,
  output logic [1:NUM_SLOTS*COORD_W]     bomb_y,
  output logic [1:NUM_SLOTS]             bomb_live,
  output logic [1:NUM_SLOTS]             crack_num,
  output logic [2:0]                     bomb_count
);
  logic [NUM_SLOTS-1:0] live_v, crack_v, busy, busy_nxt, dup, free_v, sel, alloc, chain_hit;
  logic [COORD_W-1:0] sx [NUM_SLOTS];
  logic [COORD_W-1:0] sy [NUM_SLOTS];
  logic accept;
  assign busy = live_v | crack_v;
  assign free_v = ~busy;
  assign sel = free_v & (~free_v + NUM_SLOTS'(1));
  assign accept = place && |free_v && !(|dup);
  assign alloc = accept ? sel : '0;
  genvar i;
  generate
    for (i = 0; i < NUM_SLOTS; i++) begin : g_slot
      bomb_slot #(.FUSE_TICKS(FUSE_TICKS), .CRACK_TICKS(CRACK_TICKS), .CNT_W(CNT_W)) u_slot (
        .clk(clk), .rst(rst), .tick(tick), .alloc(alloc[i]), .chain_hit(chain_hit[i]),
        .place_x(place_x), .place_y(place_y), .live(live_v[i]), .crack(crack_v[i]),
        .busy_next(busy_nxt[i]), .x(sx[i]), .y(sy[i])
      );
      assign dup[i] = busy[i] && sx[i] == place_x && sy[i] == place_y;
      assign bomb_x[COORD_W*i+1:COORD_W*i+COORD_W] = sx[i];
      assign bomb_y[COORD_W*i+1:COORD_W*i+COORD_W] = sy[i];
      assign bomb_live[i+1] = live_v[i];
      assign crack_num[i+1] = crack_v[i];
    end
  endgenerate
`ifdef CHAIN_REACT_EN
  // a burning fuse shares an odd row or column with an exploding slot: detonate it
  always_comb begin
    chain_hit = '0;
    for (int k = 0; k < NUM_SLOTS; k++)
      for (int j = 0; j < NUM_SLOTS; j++)
        if (crack_v[j] && ((sx[j] == sx[k] && sx[k][0]) || (sy[j] == sy[k] && sy[k][0])))
          chain_hit[k] = 1'b1;
  end
`else
  assign chain_hit = '0;
`endif
  // request result pulses and occupancy count as seen after this edge
  always_ff @(posedge clk) begin
    if (rst) begin
      place_ok <= 1'b0;
      place_rej <= 1'b0;
      bomb_count <= '0;
    end else begin
      place_ok <= accept;
      place_rej <= place && !accept;
      bomb_count <= popcount6(busy_nxt);
    end
  end
endmodule

// File: tb/tb_bomb_slot_manager.sv
// tb_bomb_slot_manager: directed vector table plus multi-cycle sequences for bomb_slot_manager
module tb_bomb_slot_manager;
  logic clk = 1'b0, rst = 1'b1, tick = 1'b0, place = 1'b0;
  logic [5:0] place_x = '0, place_y = '0;
  logic place_ok, place_rej;
  logic [1:36] bomb_x, bomb_y;
  logic [1:6] bomb_live, crack_num;
  logic [2:0] bomb_count;
  int checks = 0, errors = 0;
  typedef struct {
    logic t, p;
    logic [5:0] px, py;
    logic ok, rej;
    logic [5:0] live, crack;
    logic [2:0] cnt;
    logic [35:0] bx, by;
  } vec_t;
  vec_t vec [16];
  bomb_slot_manager #(.FUSE_TICKS(4), .CRACK_TICKS(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .tick(tick), .place(place), .place_x(place_x), .place_y(place_y),
    .place_ok(place_ok), .place_rej(place_rej), .bomb_x(bomb_x), .bomb_y(bomb_y),
    .bomb_live(bomb_live), .crack_num(crack_num), .bomb_count(bomb_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step(input logic t, input logic p, input logic [5:0] x, input logic [5:0] y);
    tick = t;
    place = p;
    place_x = x;
    place_y = y;
    @(posedge clk);
    #1;
    tick = 1'b0;
    place = 1'b0;
    chk("exclusive", 64'(bomb_live & crack_num), 64'd0);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  task automatic chk_all_zero(input string name);
    chk({name, "_ok"}, 64'(place_ok), 64'd0);
    chk({name, "_rej"}, 64'(place_rej), 64'd0);
    chk({name, "_x"}, 64'(bomb_x), 64'd0);
    chk({name, "_y"}, 64'(bomb_y), 64'd0);
    chk({name, "_live"}, 64'(bomb_live), 64'd0);
    chk({name, "_crack"}, 64'(crack_num), 64'd0);
    chk({name, "_cnt"}, 64'(bomb_count), 64'd0);
  endtask
  initial begin
    logic [1:36] bx;
    vec[0]  = '{1'b0, 1'b1, 6'd3, 6'd5, 1'b1, 1'b0, 6'b100000, 6'b000000, 3'd1, {6'd3, 30'd0}, {6'd5, 30'd0}};
    vec[1]  = '{1'b1, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 6'b100000, 6'b000000, 3'd1, {6'd3, 30'd0}, {6'd5, 30'd0}};
    vec[2]  = vec[1];
    vec[3]  = vec[1];
    vec[4]  = '{1'b1, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 6'b000000, 6'b100000, 3'd1, {6'd3, 30'd0}, {6'd5, 30'd0}};
    vec[5]  = vec[4];
    vec[6]  = '{1'b1, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 6'b000000, 6'b000000, 3'd0, 36'd0, 36'd0};
    vec[7]  = '{1'b0, 1'b1, 6'd7, 6'd7, 1'b1, 1'b0, 6'b100000, 6'b000000, 3'd1, {6'd7, 30'd0}, {6'd7, 30'd0}};
    vec[8]  = '{1'b0, 1'b1, 6'd7, 6'd7, 1'b0, 1'b1, 6'b100000, 6'b000000, 3'd1, {6'd7, 30'd0}, {6'd7, 30'd0}};
    vec[9]  = '{1'b1, 1'b1, 6'd2, 6'd2, 1'b1, 1'b0, 6'b110000, 6'b000000, 3'd2, {6'd7, 6'd2, 24'd0}, {6'd7, 6'd2, 24'd0}};
    vec[10] = '{1'b1, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 6'b110000, 6'b000000, 3'd2, {6'd7, 6'd2, 24'd0}, {6'd7, 6'd2, 24'd0}};
    vec[11] = vec[10];
    vec[12] = '{1'b1, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 6'b010000, 6'b100000, 3'd2, {6'd7, 6'd2, 24'd0}, {6'd7, 6'd2, 24'd0}};
    vec[13] = '{1'b1, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 6'b000000, 6'b110000, 3'd2, {6'd7, 6'd2, 24'd0}, {6'd7, 6'd2, 24'd0}};
    vec[14] = '{1'b1, 1'b1, 6'd7, 6'd7, 1'b0, 1'b1, 6'b000000, 6'b010000, 3'd1, {6'd0, 6'd2, 24'd0}, {6'd0, 6'd2, 24'd0}};
    vec[15] = '{1'b0, 1'b1, 6'd7, 6'd7, 1'b1, 1'b0, 6'b100000, 6'b010000, 3'd2, {6'd7, 6'd2, 24'd0}, {6'd7, 6'd2, 24'd0}};
    @(posedge clk);
    #1;
    chk_all_zero("reset");
    do_reset();
    for (int v = 0; v < 16; v++) begin
      step(vec[v].t, vec[v].p, vec[v].px, vec[v].py);
      chk($sformatf("v%0d_ok", v), 64'(place_ok), 64'(vec[v].ok));
      chk($sformatf("v%0d_rej", v), 64'(place_rej), 64'(vec[v].rej));
      chk($sformatf("v%0d_live", v), 64'(bomb_live), 64'(vec[v].live));
      chk($sformatf("v%0d_crack", v), 64'(crack_num), 64'(vec[v].crack));
      chk($sformatf("v%0d_cnt", v), 64'(bomb_count), 64'(vec[v].cnt));
      chk($sformatf("v%0d_x", v), 64'(bomb_x), 64'(vec[v].bx));
      chk($sformatf("v%0d_y", v), 64'(bomb_y), 64'(vec[v].by));
    end
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 6'(i + 1), 6'd20);
      chk($sformatf("fill%0d_ok", i), 64'(place_ok), 64'd1);
      chk($sformatf("fill%0d_cnt", i), 64'(bomb_count), 64'(i + 1));
    end
    step(1'b0, 1'b1, 6'd9, 6'd9);
    chk("full_rej", 64'(place_rej), 64'd1);
    chk("full_ok", 64'(place_ok), 64'd0);
    chk("full_cnt", 64'(bomb_count), 64'd6);
    chk("full_live", 64'(bomb_live), 64'b111111);
    chk("full_x", 64'(bomb_x), 64'({6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6}));
    do_reset();
    step(1'b0, 1'b1, 6'd10, 6'd10);
    step(1'b0, 1'b1, 6'd11, 6'd11);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 6'd0, 6'd0);
    step(1'b0, 1'b1, 6'd12, 6'd12);
    chk("reuse_pre_live", 64'(bomb_live), 64'b111000);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 6'd0, 6'd0);
    chk("reuse_freed", 64'(bomb_live | crack_num), 64'b001000);
    step(1'b0, 1'b1, 6'd20, 6'd20);
    chk("reuse_s1_live", 64'(bomb_live), 64'b101000);
    step(1'b0, 1'b1, 6'd1, 6'd1);
    chk("reuse_s2_ok", 64'(place_ok), 64'd1);
    bx = bomb_x;
    chk("reuse_s2_x", 64'(bx[7:12]), 64'd1);
    chk("reuse_s2_live", 64'(bomb_live), 64'b111000);
    chk("reuse_cnt", 64'(bomb_count), 64'd3);
    rst = 1'b1;
    place = 1'b1;
    place_x = 6'd5;
    place_y = 6'd5;
    @(posedge clk);
    #1;
    rst = 1'b0;
    place = 1'b0;
    chk_all_zero("midrst");
    step(1'b0, 1'b1, 6'd1, 6'd1);
    chk("postrst_ok", 64'(place_ok), 64'd1);
    chk("postrst_live", 64'(bomb_live), 64'b100000);
    chk("postrst_x", 64'(bomb_x), 64'({6'd1, 30'd0}));
    do_reset();
    step(1'b0, 1'b1, 6'd3, 6'd4);
    step(1'b1, 1'b0, 6'd0, 6'd0);
    step(1'b1, 1'b0, 6'd0, 6'd0);
    step(1'b0, 1'b1, 6'd3, 6'd8);
    step(1'b1, 1'b0, 6'd0, 6'd0);
    step(1'b1, 1'b0, 6'd0, 6'd0);
    chk("chain_a_crack", 64'(crack_num), 64'b100000);
    chk("chain_b_live", 64'(bomb_live), 64'b010000);
    step(1'b1, 1'b0, 6'd0, 6'd0);
`ifdef CHAIN_REACT_EN
    chk("chain_hop_crack", 64'(crack_num), 64'b110000);
    chk("chain_hop_live", 64'(bomb_live), 64'b000000);
`else
    chk("nochain_crack", 64'(crack_num), 64'b100000);
    chk("nochain_live", 64'(bomb_live), 64'b010000);
`endif
    step(1'b1, 1'b0, 6'd0, 6'd0);
    chk("chain_end_crack", 64'(crack_num), 64'b010000);
    chk("chain_end_cnt", 64'(bomb_count), 64'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
